// File: rtl/phy_tx_scheduler.sv
// Two-lane transmit scheduler: one byte per 8-cycle frame is serialised MSB
// first on data_out. After reset a run of COM frames aligns the far end, then
// the lanes are round-robin arbitrated at every frame boundary, with IDLE
// filling frames no lane claimed.
module phy_tx_scheduler #(
    parameter int         NUM_SYNC  = 4,
    parameter logic [7:0] COM_BYTE  = 8'hBC,
    parameter logic [7:0] IDLE_BYTE = 8'h7C
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] in0_data,
    input  logic       in0_valid,
    output logic       in0_ready,
    input  logic [7:0] in1_data,
    input  logic       in1_valid,
    output logic       in1_ready,
    output logic       data_out,
    output logic       valid_out,
    output logic       lane_out,
    output logic [2:0] phase,
    output logic       frame_start,
    output logic       active
);

    // sync_cnt only ever counts 0..NUM_SYNC-1
    localparam int CNT_W = (NUM_SYNC > 1) ? $clog2(NUM_SYNC) : 1;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(NUM_SYNC - 1);

    typedef enum logic {
        ST_SYNC,
        ST_RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       phase_reg, phase_next;
    logic [7:0]       shift_reg, shift_next;
    logic             valid_reg, valid_next;
    logic             lane_reg, lane_next;
    logic [CNT_W-1:0] sync_cnt_reg, sync_cnt_next;
    logic             rr_ptr_reg, rr_ptr_next;

    logic [1:0] lane_valid;
    logic [7:0] lane_data [2];
    logic [1:0] lane_ready;
    logic       load_edge;
    logic       arb_en;
    logic       grant_valid;
    logic       grant_lane;

    assign lane_valid   = {in1_valid, in0_valid};
    assign lane_data[0] = in0_data;
    assign lane_data[1] = in1_data;

    // Arbitration happens on the load edge of every RUN frame and also on the
    // last COM frame, so the first data frame follows sync with no gap.
    assign load_edge = (phase_reg == 3'd7);
    assign arb_en    = load_edge && ((state_reg == ST_RUN) || (sync_cnt_reg == SYNC_LAST));

    // Pick a lane: a lone requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = 1'b0;
        if (arb_en) begin
            case (lane_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_lane  = 1'b0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_lane  = 1'b1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_lane  = rr_ptr_reg;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_lane  = 1'b0;
                end
            endcase
        end
    end

    // Ready goes only to the granted lane, and never while reset is held so a
    // byte is not consumed on an edge that will discard it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign lane_ready[gi] = reset && grant_valid && (grant_lane == (gi != 0));
        end
    endgenerate

    assign in0_ready = lane_ready[0];
    assign in1_ready = lane_ready[1];

    // Next-state logic: shift within a frame, reload on the phase-7 edge.
    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg + 3'd1;
        shift_next    = {shift_reg[6:0], 1'b0};
        valid_next    = valid_reg;
        lane_next     = lane_reg;
        sync_cnt_next = sync_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        if (load_edge) begin
            if (arb_en) begin
                state_next = ST_RUN;
                if (grant_valid) begin
                    shift_next  = lane_data[grant_lane];
                    valid_next  = 1'b1;
                    lane_next   = grant_lane;
                    rr_ptr_next = ~grant_lane;
                end else begin
                    shift_next = IDLE_BYTE;
                    valid_next = 1'b0;
                    lane_next  = 1'b0;
                end
            end else begin
                shift_next    = COM_BYTE;
                valid_next    = 1'b0;
                lane_next     = 1'b0;
                sync_cnt_next = sync_cnt_reg + CNT_W'(1);
            end
        end
    end

    // State registers; an active-low reset restarts the COM sequence from a
    // fresh frame, dropping any partially sent byte.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state_reg    <= ST_SYNC;
            phase_reg    <= 3'd0;
            shift_reg    <= COM_BYTE;
            valid_reg    <= 1'b0;
            lane_reg     <= 1'b0;
            sync_cnt_reg <= '0;
            rr_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            shift_reg    <= shift_next;
            valid_reg    <= valid_next;
            lane_reg     <= lane_next;
            sync_cnt_reg <= sync_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    assign data_out    = shift_reg[7];
    assign valid_out   = valid_reg;
    assign lane_out    = lane_reg;
    assign phase       = phase_reg;
    assign frame_start = (phase_reg == 3'd0);
    assign active      = (state_reg == ST_RUN);

endmodule
